// File: rtl/counter_bcd_pkg.sv
// Shared BCD types and elaboration-time helpers for the multi-digit BCD counters.
package counter_bcd_pkg;

   localparam int BCD_DIGIT_W    = 4;
   localparam int BCD_MAX_DIGITS = 8;
   localparam int BCD_MAX_W      = BCD_DIGIT_W * BCD_MAX_DIGITS;

   typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
   typedef logic [BCD_MAX_W-1:0]   bcd_vec_t;

   function automatic bcd_vec_t to_bcd(input int value, input int digits);
      bcd_vec_t r = '0;
      int       v = value;
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
         if (i < digits) begin
            r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_digit_t'(v % 10);
            v = v / 10;
         end
      end
      return r;
   endfunction

   function automatic logic bcd_valid(input bcd_vec_t v);
      logic ok = 1'b1;
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
         if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the up/down chain; purely combinational, zero latency.
// cout is carry out when counting up and borrow out when counting down.
module bcd_digit_step
   import counter_bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   input  logic                   cin,
   input  logic                   up_dn,
   output logic [BCD_DIGIT_W-1:0] digit_nxt,
   output logic                   cout
);

   always_comb begin
      digit_nxt = digit;
      cout      = 1'b0;
      if (cin) begin
         if (up_dn) begin
            if (digit >= 4'd9) begin
               digit_nxt = 4'd0;
               cout      = 1'b1;
            end else begin
               digit_nxt = digit + 4'd1;
            end
         end else begin
            if (digit == 4'd0) begin
               digit_nxt = 4'd9;
               cout      = 1'b1;
            end else begin
               digit_nxt = digit - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/counter_bcd_multi.sv
// Multi-digit BCD up/down counter (0..MAX_VAL) with checked load; count/wrap/load_err one
// falling edge after inputs, tc combinational. No backpressure: steps on every enabled edge.
module counter_bcd_multi
   import counter_bcd_pkg::*;
#(
   parameter int DIGITS  = 4,
   parameter int MAX_VAL = 9999
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          up_dn,
   input  logic                          load,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] load_val,
   output logic [BCD_DIGIT_W*DIGITS-1:0] count,
   output logic                          tc,
   output logic                          wrap,
   output logic                          load_err
);

   localparam int W = BCD_DIGIT_W * DIGITS;

   if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS) begin : g_bad_digits
      $error("counter_bcd_multi: DIGITS out of range");
   end
   if (MAX_VAL < 1 || MAX_VAL > (10 ** DIGITS) - 1) begin : g_bad_max
      $error("counter_bcd_multi: MAX_VAL out of range for DIGITS");
   end

   localparam bcd_vec_t       MAX_BCD_FULL = to_bcd(MAX_VAL, DIGITS);
   localparam logic [W-1:0]   MAX_BCD      = MAX_BCD_FULL[W-1:0];

   logic [W-1:0]  count_q, count_d, step_val;
   logic          wrap_q, wrap_d, load_err_q, load_err_d;
   logic [DIGITS:0] chain;
   bcd_vec_t      count_ext, load_ext;
   logic          at_max, at_zero, count_ok, load_ok, wrap_now;

   assign chain[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_step u_step (
         .digit     (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .cin       (chain[i]),
         .up_dn     (up_dn),
         .digit_nxt (step_val[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .cout      (chain[i+1])
      );
   end

   always_comb begin
      count_ext         = '0;
      count_ext[W-1:0]  = count_q;
      load_ext          = '0;
      load_ext[W-1:0]   = load_val;
   end

   assign at_max   = (count_q == MAX_BCD);
   assign at_zero  = (count_q == '0);
   // Once every nibble is a legal digit, unsigned compare of packed BCD equals decimal compare.
   assign count_ok = bcd_valid(count_ext) && (count_q <= MAX_BCD);
   assign load_ok  = bcd_valid(load_ext) && (load_val <= MAX_BCD);
   // Chain overflow only fires at all-nines / all-zeros, both already wrap points.
   assign wrap_now = ~count_ok | chain[DIGITS] | (up_dn ? at_max : at_zero);

   assign tc = enable & ~load & ~reset & (up_dn ? at_max : at_zero);

   always_comb begin
      count_d    = count_q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (reset) begin
         count_d = '0;
      end else if (load) begin
         if (load_ok) count_d    = load_val;
         else         load_err_d = 1'b1;
      end else if (enable) begin
         if (wrap_now) begin
            count_d = up_dn ? '0 : MAX_BCD;
            wrap_d  = 1'b1;
         end else begin
            count_d = step_val;
         end
      end
   end

   always_ff @(negedge clk) begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
   end

   assign count    = count_q;
   assign wrap     = wrap_q;
   assign load_err = load_err_q;

endmodule
